// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - frame-based program image loader driving the memory write port and CPU reset.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 256,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_n;
  logic [15:0]   len, len_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [23:0]   word_buf, word_buf_n;
  logic [7:0]    checksum, checksum_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          mem_we_n;
  logic [31:0]   mem_addr_n, mem_wdata_n;
  logic          cpu_reset_n, done_n, err_n;
  logic [15:0]   words_loaded_n;
  logic          timing_state, timed_out;
  logic [15:0]   len_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN0;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      checksum     <= '0;
      tcnt         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      byte_idx     <= byte_idx_n;
      word_buf     <= word_buf_n;
      checksum     <= checksum_n;
      tcnt         <= tcnt_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      cpu_reset    <= cpu_reset_n;
      done         <= done_n;
      err          <= err_n;
      words_loaded <= words_loaded_n;
    end
  end

  always_comb begin
    state_n        = state;
    len_n          = len;
    byte_idx_n     = byte_idx;
    word_buf_n     = word_buf;
    checksum_n     = checksum;
    tcnt_n         = tcnt;
    mem_we_n       = 1'b0;
    mem_addr_n     = mem_addr;
    mem_wdata_n    = mem_wdata;
    cpu_reset_n    = cpu_reset;
    done_n         = done;
    err_n          = err;
    words_loaded_n = words_loaded;
    len_full       = {rx_byte, len[7:0]};

    // Inter-byte timeout only runs once a frame has started; it saturates at the limit.
    timing_state = (state == S_LEN1) || (state == S_DATA) || (state == S_CHK);
    timed_out    = timing_state && (tcnt == TW'(TIMEOUT_CYC));
    if (timing_state) begin
      if (rx_valid) begin
        tcnt_n = '0;
      end else if (!timed_out) begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    if (timed_out) begin
      state_n = S_ERR;
      err_n   = 1'b1;
    end else begin
      case (state)
        S_LEN0: begin
          if (rx_valid) begin
            len_n[7:0] = rx_byte;
            state_n    = S_LEN1;
          end
        end
        S_LEN1: begin
          if (rx_valid) begin
            len_n = len_full;
            if ((len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS))) begin
              state_n = S_ERR;
              err_n   = 1'b1;
            end else begin
              state_n = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            checksum_n = checksum ^ rx_byte;
            byte_idx_n = byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf_n[7:0]   = rx_byte;
              2'd1: word_buf_n[15:8]  = rx_byte;
              2'd2: word_buf_n[23:16] = rx_byte;
              default: begin
                mem_we_n       = 1'b1;
                mem_wdata_n    = {rx_byte, word_buf};
                mem_addr_n     = BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded_n = words_loaded + 16'd1;
                if (words_loaded_n == len) begin
                  state_n = S_CHK;
                end
              end
            endcase
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            if (rx_byte == checksum) begin
              state_n     = S_DONE;
              done_n      = 1'b1;
              cpu_reset_n = 1'b0;
            end else begin
              state_n = S_ERR;
              err_n   = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader with randomized frames and a byte-level model.
module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 8;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  boot_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wl;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] pbuf[$];
  int         wl_model;
  logic [7:0] xor_acc;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wl_model = 0;
    xor_acc  = 8'h00;
    pbuf.delete();
  endtask

  task automatic send_hdr(input int n);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
  endtask

  // Model: every completed group of 4 data bytes is one write at BASE + 4*index.
  task automatic send_data_byte(input logic [7:0] b, input int gap);
    idle(gap);
    send_byte(b);
    xor_acc = xor_acc ^ b;
    pbuf.push_back(b);
    if (pbuf.size() == 4) begin
      exp_q.push_back('{BASE + 32'(4 * wl_model), {pbuf[3], pbuf[2], pbuf[1], pbuf[0]}, wl_model + 1, cyc});
      wl_model++;
      pbuf.delete();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_data_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic send_chk(input string tag, input bit flip);
    chk({tag, "_cpu_reset_before_chk"}, cpu_reset, 1'b1);
    send_byte(flip ? (xor_acc ^ 8'h01) : xor_acc);
    chk({tag, "_done"}, done, !flip);
    chk({tag, "_err"}, err, flip);
    chk({tag, "_cpu_reset"}, cpu_reset, flip);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    wl_model = 0;
    xor_acc  = 8'h00;
    fork
      begin
        forever begin
          @(negedge clk);
          if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: got mem_we=1 addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", mem_addr, e.addr);
              chk("wr_data", mem_wdata, e.data);
              chk("wr_words_loaded", 32'(words_loaded), 32'(e.wl));
              chk("wr_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
          end
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_words_loaded", 32'(words_loaded), 32'h0);

        // Directed frame, then bytes after done must be ignored.
        do_reset();
        send_hdr(2);
        send_word(32'h2008_0005, 0);
        send_word(32'h0000_0000, 0);
        send_chk("t1", 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(2);
        chk("t1_words_loaded", 32'(words_loaded), 32'd2);
        chk("t1_done_sticky", done, 1'b1);

        do_reset();
        send_hdr(2);
        send_word(32'h2008_0005, 1);
        send_word(32'h0000_0000, 1);
        send_chk("t2", 1'b1);
        idle(2);
        chk("t2_words_loaded", 32'(words_loaded), 32'd2);

        // Illegal lengths: zero, one above the limit, high byte set.
        do_reset();
        send_hdr(0);
        chk("len0_err", err, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        chk("len0_cpu_reset", cpu_reset, 1'b1);
        do_reset();
        send_hdr(MAXW + 1);
        chk("lenmax1_err", err, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        chk("lenmax1_done", done, 1'b0);
        do_reset();
        send_hdr(16'h0101);
        chk("lenhi_err", err, 1'b1);

        // Timeout mid-word.
        do_reset();
        send_hdr(1);
        send_data_byte(8'h11, 0);
        send_data_byte(8'h22, 0);
        idle(4);
        chk("tout_early_err", err, 1'b0);
        idle(TOUT + 4);
        chk("tout_err", err, 1'b1);
        chk("tout_cpu_reset", cpu_reset, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h33);
        idle(2);
        chk("tout_err_sticky", err, 1'b1);
        chk("tout_done", done, 1'b0);

        // Reset mid-load, then a fresh single-word frame.
        do_reset();
        send_hdr(3);
        send_word(32'hCAFE_F00D, 0);
        send_data_byte(8'h5A, 0);
        do_reset();
        chk("midrst_words_loaded", 32'(words_loaded), 32'd0);
        chk("midrst_mem_addr", mem_addr, BASE);
        send_hdr(1);
        send_word(32'h1234_5678, 2);
        send_chk("t5", 1'b0);
        idle(2);
        chk("t5_words_loaded", 32'(words_loaded), 32'd1);

        // Reset sampled together with a word's 4th byte cancels its write.
        do_reset();
        send_hdr(2);
        for (int i = 0; i < 3; i++) send_data_byte(8'(i + 1), 0);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h44;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        wl_model = 0;
        xor_acc  = 8'h00;
        pbuf.delete();
        chk("cancel_mem_we", mem_we, 1'b0);
        chk("cancel_mem_wdata", mem_wdata, 32'h0);
        idle(2);

        // Back-to-back bytes.
        do_reset();
        send_hdr(4);
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        send_chk("t6", 1'b0);
        idle(2);
        chk("t6_words_loaded", 32'(words_loaded), 32'd4);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
          int  n;
          bit  flip;
          do_reset();
          n    = $urandom_range(1, MAXW);
          flip = ($urandom_range(0, 3) == 0);
          send_hdr(n);
          for (int w = 0; w < n; w++) send_word($urandom, 3);
          send_chk("rnd", flip);
          idle(2);
          chk("rnd_words_loaded", 32'(words_loaded), 32'(n));
        end
        idle(3);
      end
    join_any
    disable fork;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
